mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single unified memory port shared by instruction fetch (IF) and the data memory stage (MEM) of the segmented pipeline. MEM-stage loads and stores are driven by the registered `LeerMem`/`EscrMem` strobes; fetch is driven by the PC stage. The block serialises the two requesters onto a req/ack memory interface, returns read data, and generates the stall signals that freeze the pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one req/ack memory port between instruction fetch
// and the MEM stage, with round-robin fairness and pipeline stall generation.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          flush_if,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          LeerMem,
  input  logic          EscrMem,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          stall,
  output logic          stall_if,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic GRANT_IF   = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_t        state_q, state_d;
  logic          lastGrant_q, lastGrant_d;
  logic          kill_q, kill_d;
  logic          memReq_q, memReq_d;
  logic          memWe_q, memWe_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic [DW-1:0] ifRdata_q, ifRdata_d;
  logic [DW-1:0] dmRdata_q, dmRdata_d;
  logic          ifDone_q, ifDone_d;
  logic          dmDone_q, dmDone_d;

  logic dreq;
  logic freq;
  logic ackSeen;

  // Done-gating keeps the same request from being granted again in its done cycle.
  assign dreq    = (LeerMem | EscrMem) & ~dmDone_q;
  assign freq    = if_req & ~flush_if & ~ifDone_q;
  assign ackSeen = mem_ack & memReq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= GRANT_IF;
      kill_q      <= 1'b0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      ifRdata_q   <= '0;
      dmRdata_q   <= '0;
      ifDone_q    <= 1'b0;
      dmDone_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      kill_q      <= kill_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      ifRdata_q   <= ifRdata_d;
      dmRdata_q   <= dmRdata_d;
      ifDone_q    <= ifDone_d;
      dmDone_q    <= dmDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    kill_d      = kill_q;
    memReq_d    = memReq_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    ifRdata_d   = ifRdata_q;
    dmRdata_d   = dmRdata_q;
    ifDone_d    = 1'b0;
    dmDone_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On contention the grant alternates away from the previous winner.
        if (dreq && (!freq || lastGrant_q == GRANT_IF)) begin
          state_d     = DATA;
          memReq_d    = 1'b1;
          memWe_d     = EscrMem;
          memAddr_d   = dm_addr;
          memWdata_d  = dm_wdata;
          lastGrant_d = GRANT_DATA;
        end else if (freq) begin
          state_d     = FETCH;
          memReq_d    = 1'b1;
          memWe_d     = 1'b0;
          memAddr_d   = if_addr;
          lastGrant_d = GRANT_IF;
          kill_d      = 1'b0;
        end
      end

      FETCH: begin
        // A flushed fetch still runs to completion; only its result is dropped.
        if (flush_if) begin
          kill_d = 1'b1;
        end
        if (ackSeen) begin
          memReq_d = 1'b0;
          state_d  = IDLE;
          if (!(kill_q || flush_if)) begin
            ifRdata_d = mem_rdata;
            ifDone_d  = 1'b1;
          end
        end
      end

      DATA: begin
        if (ackSeen) begin
          memReq_d = 1'b0;
          state_d  = IDLE;
          dmDone_d = 1'b1;
          if (!memWe_q) begin
            dmRdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall     = dreq;
  assign stall_if  = dreq | freq;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign if_rdata  = ifRdata_q;
  assign if_done   = ifDone_q;
  assign dm_rdata  = dmRdata_q;
  assign dm_done   = dmDone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: pipeline-like requesters and a wait-state memory drive the
// arbiter; a transaction-level model predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NUM_CYCLES = 4000;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          flush_if;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          LeerMem;
  logic          EscrMem;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          stall;
  logic          stall_if;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush_if  (flush_if),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .LeerMem   (LeerMem),
    .EscrMem   (EscrMem),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .stall     (stall),
    .stall_if  (stall_if),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Backing store seen by the memory model; unwritten words have a fixed hash.
  logic [31:0] memArr [logic [31:0]];

  // Transaction-level view: who owns the port (0 none, 1 fetch, 2 data).
  int          owner     = 0;
  bit          lastData  = 1'b0;
  bit          killed    = 1'b0;
  int          waitLeft  = 0;
  bit          eReq      = 1'b0;
  bit          eWe       = 1'b0;
  logic [31:0] eAddr     = '0;
  logic [31:0] eWdata    = '0;
  bit          eIfDone   = 1'b0;
  bit          eDmDone   = 1'b0;
  logic [31:0] eIfData   = '0;
  logic [31:0] eDmData   = '0;

  bit dataActive  = 1'b0;
  bit fetchActive = 1'b0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input int cyc);
    logic [31:0] pick;
    int          kind;
    bit          flushNow;

    rst_n = !(cyc < 2 || $urandom_range(0, 199) == 0);

    // Data side behaves like the MEM stage: strobes held until the done pulse.
    if (eDmDone) begin
      dataActive = 1'b0;
    end else if (!dataActive) begin
      if ($urandom_range(0, 1) == 1) begin
        kind     = int'($urandom_range(0, 3));
        pick     = 32'($urandom_range(0, 7));
        LeerMem  = (kind != 2);
        EscrMem  = (kind >= 2);
        dm_addr  = 32'h100 + (pick << 2);
        dm_wdata = $urandom;
        dataActive = 1'b1;
      end else begin
        LeerMem  = 1'b0;
        EscrMem  = 1'b0;
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
    end

    // Fetch side: PC held until if_done; occasional one-cycle redirects.
    flush_if = 1'b0;
    if (eIfDone) begin
      fetchActive = 1'b0;
    end else if (fetchActive) begin
      flushNow = ($urandom_range(0, 7) == 0);
      if (flushNow) begin
        pick     = 32'($urandom_range(0, 63));
        flush_if = 1'b1;
        if_addr  = 32'h40 + (pick << 2);
      end
    end else if ($urandom_range(0, 9) < 7) begin
      pick        = 32'($urandom_range(0, 63));
      if_req      = 1'b1;
      if_addr     = 32'h40 + (pick << 2);
      fetchActive = 1'b1;
    end else begin
      if_req = 1'b0;
    end
    if (fetchActive) if_req = 1'b1;

    // Memory: ack after the chosen wait count; stray acks while the port is idle.
    if (cyc < 2) begin
      mem_ack = 1'b1;
    end else if (owner != 0) begin
      mem_ack = (waitLeft == 0);
    end else begin
      mem_ack = ($urandom_range(0, 3) == 0);
    end
    if (owner != 0 && waitLeft == 0 && !(owner == 2 && eWe)) begin
      mem_rdata = memRead(eAddr);
    end else begin
      mem_rdata = $urandom;
    end
  endtask

  task automatic checkCycle();
    bit dreqE;
    bit freqE;
    dreqE = (LeerMem | EscrMem) & ~eDmDone;
    freqE = if_req & ~flush_if & ~eIfDone;
    checkOutput("mem_req",   {31'b0, mem_req},  {31'b0, eReq});
    checkOutput("mem_we",    {31'b0, mem_we},   {31'b0, eWe});
    checkOutput("mem_addr",  mem_addr,          eAddr);
    checkOutput("mem_wdata", mem_wdata,         eWdata);
    checkOutput("if_done",   {31'b0, if_done},  {31'b0, eIfDone});
    checkOutput("if_rdata",  if_rdata,          eIfData);
    checkOutput("dm_done",   {31'b0, dm_done},  {31'b0, eDmDone});
    checkOutput("dm_rdata",  dm_rdata,          eDmData);
    checkOutput("stall",     {31'b0, stall},    {31'b0, dreqE});
    checkOutput("stall_if",  {31'b0, stall_if}, {31'b0, dreqE | freqE});
  endtask

  task automatic updateModel();
    bit dreqE;
    bit freqE;
    bit nIfDone;
    bit nDmDone;

    if (!rst_n) begin
      owner    = 0;
      lastData = 1'b0;
      killed   = 1'b0;
      eReq     = 1'b0;
      eWe      = 1'b0;
      eAddr    = '0;
      eWdata   = '0;
      eIfDone  = 1'b0;
      eDmDone  = 1'b0;
      eIfData  = '0;
      eDmData  = '0;
      return;
    end

    dreqE   = (LeerMem | EscrMem) & ~eDmDone;
    freqE   = if_req & ~flush_if & ~eIfDone;
    nIfDone = 1'b0;
    nDmDone = 1'b0;

    if (owner == 0) begin
      // Round robin: a lone requester wins; both -> whoever did not win last.
      if (dreqE && (!freqE || !lastData)) begin
        owner    = 2;
        lastData = 1'b1;
        eReq     = 1'b1;
        eWe      = EscrMem;
        eAddr    = dm_addr;
        eWdata   = dm_wdata;
        waitLeft = int'($urandom_range(0, 3));
      end else if (freqE) begin
        owner    = 1;
        lastData = 1'b0;
        killed   = 1'b0;
        eReq     = 1'b1;
        eWe      = 1'b0;
        eAddr    = if_addr;
        waitLeft = int'($urandom_range(0, 3));
      end
    end else if (owner == 2) begin
      if (mem_ack) begin
        owner   = 0;
        eReq    = 1'b0;
        nDmDone = 1'b1;
        if (eWe) memArr[eAddr] = eWdata;
        else     eDmData = memRead(eAddr);
      end else begin
        waitLeft--;
      end
    end else begin
      if (flush_if) killed = 1'b1;
      if (mem_ack) begin
        owner = 0;
        eReq  = 1'b0;
        if (!killed) begin
          nIfDone = 1'b1;
          eIfData = memRead(eAddr);
        end
      end else begin
        waitLeft--;
      end
    end

    eIfDone = nIfDone;
    eDmDone = nDmDone;
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h40;
    flush_if  = 1'b0;
    LeerMem   = 1'b0;
    EscrMem   = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b1;
    fetchActive = 1'b1;

    $display("[TB] starting %0d randomized cycles", NUM_CYCLES);
    @(posedge clk);
    updateModel();

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(negedge clk);
      applyStimulus(cyc);
      #1;
      checkCycle();
      @(posedge clk);
      updateModel();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
